keypad_scan_hex: RTL

- Scans a 4x4 hex keypad matrix by driving one column low at a time and reading the row lines.
- Debounces the press, then emits a 4-bit hex key code with a one-cycle valid strobe.
- Shifts the last two codes into an 8-bit byte `n`, which connects directly to the byte input of the two-digit hex display driver. The block is the input-side counterpart of that multiplexed display.

---
 rtl/keypad_pkg.sv | 40 ++++
 rtl/sync_2ff.sv | 32 +++
 rtl/keypad_scan_hex.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 hex keypad scanner.
//   state_t    : scanner FSM states
//   KEY_W      : width of a key code
//   NUM_ROWS   : keypad row lines
//   NUM_COLS   : keypad column lines
//   COL_IDLE   : column drive pattern after reset (column 0 low)
//   lowest_low : index of the lowest-numbered low row bit (row 0 wins)
//   col_drive  : active-low one-cold column pattern for a column index
package keypad_pkg;

  localparam int KEY_W    = 4;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  localparam logic [NUM_COLS-1:0] COL_IDLE = 4'b1110;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Scan from the top row down so the lowest low row is the last one kept.
  function automatic logic [1:0] lowest_low(input logic [NUM_ROWS-1:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!r[i]) idx = i[1:0];
    end
    return idx;
  endfunction

  function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] idx);
    logic [NUM_COLS-1:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous level inputs.
//   clk   : destination clock
//   reset : synchronous, active-high; both stages reset to all-ones
//   d     : asynchronous input bus (DATA_W bits)
//   q     : synchronised output bus (DATA_W bits)
module sync_2ff #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] sync_p0;
  logic [DATA_W-1:0] sync_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      // stage p0: first capture, may be metastable
      sync_p0 <= d;
      // stage p1: settled copy used by the consumer
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/keypad_scan_hex.sv
// keypad_scan_hex: 4x4 hex keypad scanner with debounce and a two-key byte.
//   clk       : system clock
//   reset     : synchronous, active-high
//   row       : keypad rows, active-low, pulled up externally
//   col       : keypad columns, active-low, exactly one low at a time
//   key       : last accepted key code (row*4 + col)
//   key_valid : one-cycle strobe when a new key is accepted
//   key_held  : high while an accepted key is held or its release debounces
//   n         : {previous key, latest key}, feeds the two-digit hex display
module keypad_scan_hex
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 28000,
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [KEY_W-1:0]    key,
  output logic                key_valid,
  output logic                key_held,
  output logic [2*KEY_W-1:0]  n
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
  // The detecting tick in SCAN is itself the first agreeing tick, so the
  // press debounce stops one count earlier than the release debounce.
  localparam logic [CNT_W-1:0] ACC_LAST =
    CNT_W'((DEBOUNCE_TICKS > 1) ? DEBOUNCE_TICKS - 2 : 0);

  logic [NUM_ROWS-1:0] rs;
  logic [PRE_W-1:0]    presc;
  logic [1:0]          col_idx;
  logic [1:0]          col_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [KEY_W-1:0]    cap_code;
  logic [KEY_W-1:0]    cur_code;
  logic                tick;
  logic                hit;
  state_t              state;

  sync_2ff #(
    .DATA_W(NUM_ROWS)
  ) u_row_sync (
    .clk  (clk),
    .reset(reset),
    .d    (row),
    .q    (rs)
  );

  assign tick     = (presc == PRE_LAST);
  assign hit      = ~&rs;
  assign cur_code = {lowest_low(rs), col_idx};
  assign col_nxt  = col_idx + 2'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc     <= '0;
      col_idx   <= 2'd0;
      col       <= COL_IDLE;
      cnt       <= '0;
      cap_code  <= '0;
      state     <= SCAN;
      key       <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      n         <= '0;
    end else begin
      key_valid <= 1'b0;
      presc     <= tick ? '0 : presc + PRE_W'(1);

      if (tick) begin
        unique case (state)
          SCAN: begin
            if (hit) begin
              cap_code <= cur_code;
              cnt      <= '0;
              if (DEBOUNCE_TICKS == 1) begin
                state     <= HELD;
                key       <= cur_code;
                n         <= {n[KEY_W-1:0], cur_code};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end else begin
                state <= DEBOUNCE;
              end
            end else begin
              col_idx <= col_nxt;
              col     <= col_drive(col_nxt);
            end
          end

          DEBOUNCE: begin
            if (hit && (cur_code == cap_code)) begin
              if (cnt == ACC_LAST) begin
                state     <= HELD;
                key       <= cap_code;
                n         <= {n[KEY_W-1:0], cap_code};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end else begin
              // Bounce or a different lowest row: give up on this column.
              state   <= SCAN;
              col_idx <= col_nxt;
              col     <= col_drive(col_nxt);
            end
          end

          HELD: begin
            // Column stays frozen, so keys in other columns are invisible.
            if (!hit) begin
              cnt   <= '0;
              state <= RELEASE;
            end
          end

          RELEASE: begin
            if (hit) begin
              state <= HELD;
            end else if (cnt == REL_LAST) begin
              key_held <= 1'b0;
              state    <= SCAN;
              col_idx  <= col_nxt;
              col      <= col_drive(col_nxt);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule
